// File: rtl/clock_gate_hyst_if.sv
// Request/status bundle between a compute stage and its hysteretic clock gate.
// The consumer drives the requests; the gate returns the gated clock and activity counters.
interface clock_gate_hyst_if #(
  parameter int CNT_W = 32
);
  logic             enable;
  logic             test_en;
  logic             clear_stats;
  logic             gclk;
  logic             gate_open;
  logic [CNT_W-1:0] active_cycles;
  logic [CNT_W-1:0] total_cycles;

  modport master (
    output enable, test_en, clear_stats,
    input  gclk, gate_open, active_cycles, total_cycles
  );

  modport slave (
    input  enable, test_en, clear_stats,
    output gclk, gate_open, active_cycles, total_cycles
  );
endinterface

// File: rtl/clock_gate_hyst.sv
// Latch-based glitch-free clock gate with turn-off hysteresis and saturating activity counters.
// gclk pulses on every edge whose low phase saw enable, test_en or a live hold window.
module clock_gate_hyst #(
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  clock_gate_hyst_if.slave  cg
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             hold_active_s;
  logic             req_s;
  logic             en_lat_q;
  logic             gate_open_q;
  logic [CNT_W-1:0] active_q;
  logic [CNT_W-1:0] active_d;
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] total_d;

  generate
    if (HOLD_CYCLES > 0) begin : g_hold
      localparam int            HW        = $clog2(HOLD_CYCLES + 1);
      localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
      localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

      logic [HW-1:0] hold_cnt_q;
      logic [HW-1:0] hold_cnt_d;

      // Hold counter next state: reload while enabled, otherwise run down to zero.
      always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (cg.enable) begin
          hold_cnt_d = HOLD_LOAD;
        end else if (hold_cnt_q != {HW{1'b0}}) begin
          hold_cnt_d = hold_cnt_q - HOLD_ONE;
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end

      // Hold counter register; reset kills any open hold window at once.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_cnt_q <= {HW{1'b0}};
        end else begin
          hold_cnt_q <= hold_cnt_d;
        end
      end

      assign hold_active_s = (hold_cnt_q != {HW{1'b0}});
    end else begin : g_no_hold
      assign hold_active_s = 1'b0;
    end
  endgenerate

  assign req_s = cg.enable | cg.test_en | hold_active_s;

  // Enable latch: open only while clk is low, so gclk can never see a mid-pulse change.
  // Deliberately not reset, so gclk keeps following enable | test_en during reset.
  always_latch begin
    if (!clk) begin
      en_lat_q <= req_s;
    end
  end

  assign cg.gclk = clk & en_lat_q;

  // Counter next state: clear wins over increment, both saturate at all-ones.
  always_comb begin
    total_d  = total_q;
    active_d = active_q;
    if (cg.clear_stats) begin
      total_d  = {CNT_W{1'b0}};
      active_d = {CNT_W{1'b0}};
    end else begin
      if (total_q != CNT_MAX) begin
        total_d = total_q + CNT_ONE;
      end else begin
        total_d = total_q;
      end
      if (en_lat_q && (active_q != CNT_MAX)) begin
        active_d = active_q + CNT_ONE;
      end else begin
        active_d = active_q;
      end
    end
  end

  // Status and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_open_q <= 1'b0;
      total_q     <= {CNT_W{1'b0}};
      active_q    <= {CNT_W{1'b0}};
    end else begin
      gate_open_q <= en_lat_q;
      total_q     <= total_d;
      active_q    <= active_d;
    end
  end

  assign cg.gate_open     = gate_open_q;
  assign cg.active_cycles = active_q;
  assign cg.total_cycles  = total_q;

endmodule

// File: tb/tb_clock_gate_hyst.sv
// Self-checking bench for clock_gate_hyst: directed scenarios plus random requests
// compared each edge against an edge-indexed reference model.
module tb_clock_gate_hyst;

  localparam int  HOLD = 2;
  localparam int  CW   = 8;
  localparam int  MAXC = (1 << CW) - 1;
  localparam time HALF = 5;

  logic clk = 1'b0;
  logic rst_n;

  clock_gate_hyst_if #(.CNT_W(CW)) bus ();

  clock_gate_hyst #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cg    (bus)
  );

  always #HALF clk = ~clk;

  int  total = 0;
  int  bad   = 0;
  bit  mon_on = 1'b0;

  // Reference model state: pulses happen on edge k when a request was seen or the
  // last enabled edge (since reset) lies at most HOLD edges back.
  int  k       = 0;
  int  last_en = -1000;
  int  m_act   = 0;
  int  m_tot   = 0;
  bit  m_go    = 1'b0;
  bit  cur_p   = 1'b0;
  int  m_pulses = 0;
  int  n_pulses = 0;
  time t_rise   = 0;
  bit  seen_rise = 1'b0;
  int  base_act;
  int  base_tot;

  always @(posedge bus.gclk) begin
    if (mon_on) begin
      n_pulses++;
      t_rise    = $time;
      seen_rise = 1'b1;
    end
  end

  // Runt detector: every gclk high pulse must last a full clk high phase.
  always @(negedge bus.gclk) begin
    if (mon_on && seen_rise) begin
      total++;
      assert (($time - t_rise) >= HALF) else begin
        bad++;
        $error("FAIL pulse_width observed=%0t expected>=%0t", $time - t_rise, HALF);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit p;
    @(posedge clk);
    if (!rst_n) begin
      p     = bus.enable | bus.test_en;
      m_go  = 1'b0;
      m_act = 0;
      m_tot = 0;
    end else begin
      p = bus.enable | bus.test_en | ((k - last_en) <= HOLD);
      if (bus.enable) last_en = k;
      if (bus.clear_stats) begin
        m_act = 0;
        m_tot = 0;
      end else begin
        if (m_tot < MAXC) m_tot++;
        if (p && (m_act < MAXC)) m_act++;
      end
      m_go = p;
    end
    k++;
    cur_p = p;
    if (mon_on && p) m_pulses++;
    #1;
    check("gclk", {31'd0, bus.gclk}, {31'd0, p});
    check("gate_open", {31'd0, bus.gate_open}, {31'd0, m_go});
    check("active_cycles", {24'd0, bus.active_cycles}, m_act);
    check("total_cycles", {24'd0, bus.total_cycles}, m_tot);
  endtask

  task automatic run(input int n, input bit en, input bit te);
    for (int i = 0; i < n; i++) begin
      bus.enable  = en;
      bus.test_en = te;
      step();
    end
  endtask

  initial begin
    rst_n           = 1'b1;
    bus.enable      = 1'b0;
    bus.test_en     = 1'b0;
    bus.clear_stats = 1'b0;
    #2;
    rst_n  = 1'b0;
    mon_on = 1'b1;
    run(3, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Idle after reset: no pulses, only total counts.
    run(10, 1'b0, 1'b0);
    check("idle_total", {24'd0, bus.total_cycles}, 10);
    check("idle_active", {24'd0, bus.active_cycles}, 0);
    check("idle_gate_open", {31'd0, bus.gate_open}, 0);

    // Five enabled edges plus two hold edges.
    run(5, 1'b1, 1'b0);
    run(6, 1'b0, 1'b0);
    check("burst_active", {24'd0, bus.active_cycles}, 7);
    check("burst_total", {24'd0, bus.total_cycles}, 21);

    // Pulse, gap, pulse: hold bridges the gap, five contiguous pulses.
    run(1, 1'b1, 1'b0);
    run(1, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0);
    run(5, 1'b0, 1'b0);
    check("gap_active", {24'd0, bus.active_cycles}, 12);

    // Enable toggled during clk high must not disturb that high phase.
    bus.enable = 1'b1;
    #1 bus.enable = 1'b0;
    #1 bus.enable = 1'b1;
    #1 check("toggle_low_phase", {31'd0, bus.gclk}, {31'd0, cur_p});
    step();
    bus.enable = 1'b0;
    #1 bus.enable = 1'b1;
    #1 bus.enable = 1'b0;
    #1 check("toggle_high_phase", {31'd0, bus.gclk}, {31'd0, cur_p});
    run(5, 1'b0, 1'b0);

    // Test override: every edge pulses.
    base_act = m_act;
    base_tot = m_tot;
    run(8, 1'b0, 1'b1);
    check("test_active_delta", {24'd0, bus.active_cycles}, base_act + 8);
    check("test_total_delta", {24'd0, bus.total_cycles}, base_tot + 8);
    run(4, 1'b0, 1'b0);

    // Reset in the middle of a hold window, then enable held through reset.
    run(3, 1'b1, 1'b0);
    run(1, 1'b0, 1'b0);
    rst_n   = 1'b0;
    last_en = -1000;
    #1;
    check("rst_active", {24'd0, bus.active_cycles}, 0);
    check("rst_total", {24'd0, bus.total_cycles}, 0);
    check("rst_gate_open", {31'd0, bus.gate_open}, 0);
    run(2, 1'b0, 1'b0);
    run(4, 1'b1, 1'b0);
    rst_n = 1'b1;
    run(3, 1'b1, 1'b0);
    run(4, 1'b0, 1'b0);

    // Random requests checked edge by edge.
    for (int i = 0; i < 100; i++) begin
      bus.enable      = ($urandom_range(0, 2) == 0);
      bus.test_en     = ($urandom_range(0, 9) == 0);
      bus.clear_stats = ($urandom_range(0, 24) == 0);
      step();
    end
    bus.enable      = 1'b1;
    bus.test_en     = 1'b0;
    bus.clear_stats = 1'b1;
    step();
    check("clear_total", {24'd0, bus.total_cycles}, 0);
    check("clear_active", {24'd0, bus.active_cycles}, 0);
    bus.clear_stats = 1'b0;

    // Saturation at all-ones.
    run(260, 1'b0, 1'b1);
    check("sat_total", {24'd0, bus.total_cycles}, MAXC);
    check("sat_active", {24'd0, bus.active_cycles}, MAXC);
    run(4, 1'b0, 1'b0);

    check("pulse_count", n_pulses, m_pulses);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=%0t expected<%0t", $time, 200000);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/clock_gate_hyst.md
Name: clock_gate_hyst

Overview:
- Glitch-free integrated clock gate (ICG) with programmable turn-off hysteresis and built-in activity counters.
- Placed in front of compute layers (e.g. conv2 stage), whose clock request is derived from valid_in, busy and state != IDLE.
- Counters feed the energy-efficiency reporting path with active versus total cycle counts.

Parameters:
- HOLD_CYCLES, 2: extra gclk cycles kept running after the last cycle in which enable was high (0 = no hysteresis).
- CNT_W, 32: width of the activity counters.

Ports:
- clk  input  1  free-running source clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  functional clock request; may be combinational from the consumer's logic.
- test_en  input  1  scan/test override; forces gclk on.
- clear_stats  input  1  synchronous clear of both counters.
- gclk  output  1  gated clock.
- gate_open  output  1  registered status; 1 when the latched enable is high.
- active_cycles  output  CNT_W  count of clk rising edges on which gclk pulsed.
- total_cycles  output  CNT_W  count of clk rising edges since reset or clear.

Behaviour:
- Effective request: req = enable | test_en | hold_active.
- Latch stage: en_lat is a level-sensitive latch, transparent while clk = 0 and holding while clk = 1.
- Gated clock: gclk = clk & en_lat.
  - A request settled before a rising edge produces a gclk pulse on that same edge, so turn-on latency is zero cycles.
  - Changes of req while clk = 1 have no effect until the next low phase.
  - gclk never produces a partial or runt high pulse.
- Hysteresis:
  - hold_cnt is a ceil(log2(HOLD_CYCLES+1))-bit down counter, clocked on the clk rising edge.
  - When enable = 1 at an edge, hold_cnt loads HOLD_CYCLES.
  - Otherwise hold_cnt decrements if nonzero.
  - hold_active = (hold_cnt != 0).
  - Net effect: gclk pulses on exactly HOLD_CYCLES edges after the last edge with enable = 1.
  - Re-assertion of enable during the hold window reloads the counter.
  - With HOLD_CYCLES = 0, hold logic is absent and hold_active = 0.
- Test mode: test_en = 1 keeps gclk equal to clk regardless of enable or hold state. Counters still count.
- gate_open: flop sampling en_lat on the clk rising edge; equals 1 for edges on which gclk pulsed.
- Counters (clk rising edge):
  - total_cycles increments every edge.
  - active_cycles increments on edges where en_lat = 1.
  - Both saturate at 2^CNT_W - 1; they do not wrap.
  - clear_stats = 1 sets both counters to 0 on that edge, taking priority over increment.
- Reset (async, rst_n = 0):
  - hold_cnt = 0, gate_open = 0, active_cycles = 0, total_cycles = 0.
  - The latch is not reset. During reset gclk still follows enable | test_en, so downstream async-reset logic sees a normal clock.
  - A reset asserted mid-hold terminates the hold window immediately.
  - Release is synchronous to the next clk rising edge, with no glitch on gclk.
- Simultaneous events:
  - enable rising while hold_cnt = 1 reloads to HOLD_CYCLES, with no gap in gclk.
  - clear_stats together with an active edge gives counters = 0, not 1.

Test Plan:
- Reset, then enable = 0 and test_en = 0 for 10 cycles -> gclk stays 0; total_cycles = 10, active_cycles = 0, gate_open = 0.
- Enable held high for exactly 5 edges, HOLD_CYCLES = 2 -> exactly 7 gclk pulses, the first on the first enable edge; active_cycles = 7; gclk then stays 0.
- Enable pulse 1 cycle, gap 1 cycle, pulse 1 cycle with HOLD_CYCLES = 2 -> gclk continuous for 5 edges with no gap; active_cycles increases by 5.
- Enable toggled while clk = 1 mid-high-phase -> no change of gclk within that high phase; full-width pulses only (checked by a pulse-width monitor, minimum = clk high time).
- test_en = 1 with enable = 0 for 8 cycles -> 8 gclk pulses; active_cycles = total_cycles delta = 8.
- rst_n pulsed low during the hold window -> hold ends at once; counters read 0; with enable = 1 held through reset, gclk toggles throughout; clear_stats asserted at 100 cycles -> both counters read 0 at the next edge.
